eoc_arbiter: RTL
================

// Module: eoc_arbiter
// PURPOSE
//  Clocked, parametrised end-of-column readout block for NCOL columns.
//  Replaces the per-column asynchronous token chain with one synchronous arbiter.
//  - Freezes the enabled column tokens and the BCID into a snapshot.
//  - Reads each snapshot column once, by fixed or round-robin priority.
//  - Tags each word with its column address and frame BCID, buffers it in a
//    show-ahead FIFO, and serves it on a valid/ready stream towards the chip periphery.
// PARAMETERS
//  NCOL       4   number of columns served (1..64)
//  DATA_W     21  column data word width
//  ADDR_W     6   column address width
//  BCID_W     6   timestamp width
//  BASE_ADDR  0   address reported for column 0; column i reports BASE_ADDR+i (mod 2^ADDR_W)
//  FIFO_DEPTH 4   output FIFO entries (power of 2, >=2)
//  RR         0   0: lowest index first; 1: round-robin, starting after the last column served
// PORTS
//  CLK      in   1             clock, all state on rising edge
//  RST      in   1             asynchronous reset, active-high
//  Enable   in   NCOL          per-column enable mask
//  TokInCol in   NCOL          column i has hit data pending
//  ColData  in   NCOL*DATA_W   column i data at [i*DATA_W +: DATA_W], valid 1 cycle after ReadCol[i]
//  Bcid     in   BCID_W        free-running bunch counter
//  ReadCol  out  NCOL          one-hot, 1-cycle read strobe to the selected column
//  Freeze   out  1             high while a snapshot is being drained
//  TokOut   out  1             |(TokInCol&Enable) | Freeze | FIFO not empty
//  Valid    out  1             FIFO head valid
//  Ready    in   1             consumer accepts head when Valid&Ready
//  DataOut  out  DATA_W        FIFO head data
//  AddrOut  out  ADDR_W        FIFO head column address
//  BcidOut  out  BCID_W        FIFO head frame BCID
// BEHAVIOUR
//  Reset: FSM=IDLE, snapshot=0, FIFO emptied, RR pointer=NCOL-1; all outputs 0.
//   Reset asserted mid-frame aborts the frame; the in-flight word is discarded.
//  FSM:
//   IDLE:    on (TokInCol&Enable)!=0 -> load snap<=TokInCol&Enable, bcid_f<=Bcid; go FREEZE.
//   FREEZE:  Freeze=1. If snap&Enable==0 -> IDLE.
//            Otherwise pick column c by priority.
//            If FIFO not full: go READ. If full: stay, ReadCol=0 (backpressure, no data loss).
//   READ:    ReadCol[c]=1 for exactly this cycle; clear snap[c]; go CAPTURE.
//   CAPTURE: write {ColData[c], BASE_ADDR+c, bcid_f} to FIFO; RR pointer<=c; go FREEZE.
//  Latency: TokInCol sampled high at edge 0 -> ReadCol at cycle 2 -> Valid at cycle 4.
//   Each column costs 3 cycles: FREEZE, READ, CAPTURE.
//  Snapshot rules:
//   - Each snap bit is read at most once per frame.
//   - Tokens rising during a frame wait for the next frame.
//   - A column still holding its token after the frame is re-frozen with a new BCID.
//  Enable drop mid-frame: that column is skipped (masked at selection); strobe already issued completes.
//  Round-robin: search starts at (ptr+1) mod NCOL and wraps.
//  Fixed priority: lowest set index wins.
//  FIFO: show-ahead. Push in CAPTURE and pop on Valid&Ready in the same cycle is legal, count unchanged.
//   Full = FIFO_DEPTH entries. READ is entered only when not full, so the CAPTURE push never overflows.
//  Address: BASE_ADDR+c truncated to ADDR_W. BCID is not incremented per word (frame timestamp).
//  ReadCol is never multi-hot and is never asserted outside READ.
// TESTING
//  1. RST high, random inputs -> ReadCol=0, Valid=0, TokOut=0, outputs 0; release -> IDLE.
//  2. NCOL=4, RR=0, TokInCol=4'b1010, Bcid=5, Ready=1 -> ReadCol 0010 then 1000.
//     Words (addr 1, bcid 5) then (addr 3, bcid 5). Freeze drops after the second CAPTURE.
//  3. RR=1, all tokens held high, two frames -> serve order 0,1,2,3, then 0,1,2,3.
//     Second frame BCID = Bcid at its freeze.
//  4. FIFO_DEPTH=2, Ready=0, 4 tokens -> 2 reads, then stall in FREEZE with ReadCol=0.
//     Ready=1 -> remaining 2 read; 4 words delivered, none lost.
//  5. Enable[2] cleared during READ of column 1 -> column 2 skipped, column 3 read next.
//  6. RST pulsed during CAPTURE -> FIFO empty, Valid=0, next frame starts clean.

Source files
------------

// File: rtl/eoc_arbiter.sv
// End-of-column readout arbiter: freezes pending column tokens with a frame BCID,
// reads each frozen column once and streams tagged words through a show-ahead FIFO.
module eoc_arbiter #(
    parameter int NCOL       = 4,
    parameter int DATA_W     = 21,
    parameter int ADDR_W     = 6,
    parameter int BCID_W     = 6,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int RR         = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NCOL-1:0]          Enable,
    input  logic [NCOL-1:0]          TokInCol,
    input  logic [NCOL*DATA_W-1:0]   ColData,
    input  logic [BCID_W-1:0]        Bcid,
    output logic [NCOL-1:0]          ReadCol,
    output logic                     Freeze,
    output logic                     TokOut,
    output logic                     Valid,
    input  logic                     Ready,
    output logic [DATA_W-1:0]        DataOut,
    output logic [ADDR_W-1:0]        AddrOut,
    output logic [BCID_W-1:0]        BcidOut
);

    localparam int COL_W   = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WORD_W  = DATA_W + ADDR_W + BCID_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FREEZE,
        ST_READ,
        ST_CAPTURE
    } state_t;

    state_t              state_reg, state_next;
    logic [NCOL-1:0]     snap_reg, snap_next;
    logic [BCID_W-1:0]   bcid_reg, bcid_next;
    logic [COL_W-1:0]    sel_reg, sel_next;
    logic [COL_W-1:0]    ptr_reg, ptr_next;

    logic [DATA_W-1:0]   col_data [NCOL];
    logic [NCOL-1:0]     cand;
    logic [NCOL-1:0]     pending;
    logic [COL_W-1:0]    pick;
    logic                found;
    int                  idx;

    logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]    count_reg;
    logic                push, pop, full, empty;
    logic [WORD_W-1:0]   wr_word, head_word;

    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_col
            assign col_data[gi] = ColData[gi*DATA_W +: DATA_W];
            assign ReadCol[gi]  = (state_reg == ST_READ) && (sel_reg == COL_W'(gi));
        end
    endgenerate

    // Enable is re-applied at every selection so a column disabled mid-frame is skipped.
    assign cand    = snap_reg & Enable;
    assign pending = TokInCol & Enable;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        if (RR != 0) begin
            for (int k = 0; k < NCOL; k++) begin
                idx = (int'(ptr_reg) + 1 + k) % NCOL;
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    pick  = COL_W'(idx);
                end
            end
        end else begin
            for (int k = NCOL - 1; k >= 0; k--) begin
                if (cand[k]) begin
                    found = 1'b1;
                    pick  = COL_W'(k);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            snap_reg  <= '0;
            bcid_reg  <= '0;
            sel_reg   <= '0;
            ptr_reg   <= COL_W'(NCOL - 1);
        end else begin
            state_reg <= state_next;
            snap_reg  <= snap_next;
            bcid_reg  <= bcid_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        snap_next  = snap_reg;
        bcid_next  = bcid_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        push       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|pending) begin
                    snap_next  = pending;
                    bcid_next  = Bcid;
                    state_next = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                if (!found) begin
                    state_next = ST_IDLE;
                end else if (!full) begin
                    // Only commit to a read when the capture slot is guaranteed.
                    sel_next   = pick;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                snap_next[sel_reg] = 1'b0;
                state_next         = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                push       = 1'b1;
                ptr_next   = sel_reg;
                state_next = ST_FREEZE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign wr_word = {col_data[sel_reg], ADDR_W'(BASE_ADDR + int'(sel_reg)), bcid_reg};

    assign full  = (count_reg == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = !empty && Ready;

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head fields are forced to zero when empty so stale memory never leaks out.
    assign head_word = fifo_mem[rd_ptr_reg];
    assign Valid     = !empty;
    assign DataOut   = Valid ? head_word[WORD_W-1 -: DATA_W]        : '0;
    assign AddrOut   = Valid ? head_word[BCID_W +: ADDR_W]          : '0;
    assign BcidOut   = Valid ? head_word[BCID_W-1:0]                : '0;

    assign Freeze = (state_reg != ST_IDLE);
    assign TokOut = !RST && ((|pending) || Freeze || !empty);

endmodule
